// File: rtl/mux_rr_arbiter_if.sv
// Requester/consumer channel of the round-robin mux arbiter.
//   req      : per-requester request, bit i = requester i
//   data_in  : packed requester words, requester i at [DATA_WIDTH*i +: DATA_WIDTH]
//   ready    : consumer accepts data_out this cycle
//   gnt      : registered one-hot grant, or 0
//   sel      : registered index of the granted requester (mux select)
//   data_out : selected word
//   valid    : data_out carries a live word
// The arbiter connects through the slave modport; the requester/consumer side
// uses the master modport.
interface mux_rr_arbiter_if #(
    parameter int DATA_WIDTH = 32
);
    logic [15:0]              req;
    logic [16*DATA_WIDTH-1:0] data_in;
    logic                     ready;
    logic [15:0]              gnt;
    logic [3:0]               sel;
    logic [DATA_WIDTH-1:0]    data_out;
    logic                     valid;

    modport master (
        output req, data_in, ready,
        input  gnt, sel, data_out, valid
    );

    modport slave (
        input  req, data_in, ready,
        output gnt, sel, data_out, valid
    );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving the select of a shared 16x1 word mux.
// Each grant covers at most MAX_BURST transfers; on release the next
// winner is loaded on the same edge, so there is no bubble between grants.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : mux_rr_arbiter_if slave (req, data_in, ready in; gnt, sel,
//         data_out, valid out)
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | no grant held; gnt=0, sel holds its last value
//   GRANT | requester sel owns the mux; cnt counts its transfers
module mux_rr_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 4
) (
    input logic               clk,
    input logic               rst,
    mux_rr_arbiter_if.slave   bus
);
    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [4:0] CNT_LAST = 5'(MAX_BURST - 1);

    state_t      state, state_n;
    logic [3:0]  ptr, ptr_n;
    logic [4:0]  cnt, cnt_n;
    logic [15:0] gnt, gnt_n;
    logic [3:0]  sel, sel_n;

    logic [3:0]  search_start;
    logic [3:0]  idx;
    logic [3:0]  win;
    logic        found;
    logic        valid;
    logic        xfer;
    logic        release_grant;

    // A release moves the pointer to sel+1, and the search on that same edge
    // must already use the new pointer, so it is taken from sel directly.
    assign search_start = (state == GRANT) ? sel + 4'd1 : ptr;

    always_comb begin
        found = 1'b0;
        win   = 4'd0;
        idx   = 4'd0;
        for (int i = 0; i < 16; i++) begin
            idx = search_start + 4'(i);
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    assign valid         = (state == GRANT) && bus.req[sel];
    assign xfer          = valid && bus.ready;
    assign release_grant = (state == GRANT) &&
                           (!bus.req[sel] || (xfer && cnt == CNT_LAST));

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        cnt_n   = cnt;
        gnt_n   = gnt;
        sel_n   = sel;
        case (state)
            IDLE: begin
                if (found) begin
                    state_n = GRANT;
                    gnt_n   = 16'h0001 << win;
                    sel_n   = win;
                    cnt_n   = 5'd0;
                end
            end
            GRANT: begin
                if (release_grant) begin
                    ptr_n = sel + 4'd1;
                    if (found) begin
                        gnt_n = 16'h0001 << win;
                        sel_n = win;
                        cnt_n = 5'd0;
                    end else begin
                        state_n = IDLE;
                        gnt_n   = 16'h0000;
                    end
                end else if (xfer) begin
                    cnt_n = cnt + 5'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= 4'd0;
            cnt   <= 5'd0;
            gnt   <= 16'h0000;
            sel   <= 4'd0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            cnt   <= cnt_n;
            gnt   <= gnt_n;
            sel   <= sel_n;
        end
    end

    assign bus.gnt      = gnt;
    assign bus.sel      = sel;
    assign bus.valid    = valid;
    assign bus.data_out = bus.data_in[DATA_WIDTH*sel +: DATA_WIDTH];
endmodule
